// File: rtl/change_payout_ctrl.sv
// Coin-ejector sequencer: pays out a change request one coin at a time with sensor
// confirmation, timeout retries and a latched jam fault. Optional abort via CHANGE_PAYOUT_ABORT_EN.
module change_payout_ctrl #(
   parameter int unsigned AMT_W       = 4,
   parameter int unsigned COIN_VAL    = 5,
   parameter int unsigned PULSE_CYC   = 4,
   parameter int unsigned TIMEOUT_CYC = 16,
   parameter int unsigned MAX_RETRY   = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             req_valid,
   input  logic [AMT_W-1:0] req_amount,
   output logic             req_ready,
   output logic             eject,
   input  logic             coin_seen,
   input  logic             fault_clr,
`ifdef CHANGE_PAYOUT_ABORT_EN
   input  logic             abort,
   output logic             aborted,
`endif
   output logic             busy,
   output logic             done,
   output logic             fault,
   output logic [AMT_W-1:0] owed,
   output logic [AMT_W-1:0] paid
);

   localparam int unsigned PW = $clog2(PULSE_CYC + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned RW = $clog2(MAX_RETRY + 2);
   localparam logic [AMT_W-1:0] Coin = AMT_W'(COIN_VAL);

   typedef enum logic [2:0] {StIdle, StPulse, StWait, StGap, StDone, StFault} state_e;

   state_e           state_q, state_d;
   logic [AMT_W-1:0] owed_q, owed_d, paid_q, paid_d;
   logic [PW-1:0]    pcnt_q, pcnt_d;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic [RW-1:0]    retry_q, retry_d;
   logic             credited_q, credited_d;
   logic             abort_req, abort_hit;

`ifdef CHANGE_PAYOUT_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif
   // DONE is already on its way back to IDLE, so abort there would only repeat done.
   assign abort_hit = abort_req && (state_q != StIdle) && (state_q != StDone);

   always_comb begin
      state_d    = state_q;
      owed_d     = owed_q;
      paid_d     = paid_q;
      pcnt_d     = pcnt_q;
      tmr_d      = tmr_q;
      retry_d    = retry_q;
      credited_d = credited_q;
      if (abort_hit) begin
         state_d = StDone;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (req_valid && req_ready) begin
                  owed_d  = req_amount - (req_amount % Coin);
                  paid_d  = '0;
                  retry_d = '0;
                  state_d = (owed_d != '0) ? StPulse : StDone;
               end
            end
            StPulse: begin
               // Only one coin may be credited per pulse even if the sensor stays high.
               if (coin_seen && !credited_q) begin
                  owed_d     = owed_q - Coin;
                  paid_d     = paid_q + Coin;
                  retry_d    = '0;
                  credited_d = 1'b1;
               end
               if (pcnt_q == PW'(PULSE_CYC - 1)) begin
                  tmr_d = '0;
                  if (credited_d) state_d = (owed_d == '0) ? StDone : StGap;
                  else            state_d = StWait;
               end else begin
                  pcnt_d = pcnt_q + 1'b1;
               end
            end
            StWait: begin
               if (coin_seen) begin
                  owed_d  = owed_q - Coin;
                  paid_d  = paid_q + Coin;
                  retry_d = '0;
                  state_d = (owed_d == '0) ? StDone : StGap;
               end else if (tmr_q == TW'(TIMEOUT_CYC - 1)) begin
                  retry_d = retry_q + 1'b1;
                  state_d = (retry_q < RW'(MAX_RETRY)) ? StPulse : StFault;
               end else begin
                  tmr_d = tmr_q + 1'b1;
               end
            end
            StGap:   state_d = StPulse;
            StDone:  state_d = StIdle;
            StFault: begin
               if (fault_clr) begin
                  retry_d = '0;
                  state_d = StPulse;
               end
            end
            default: state_d = StIdle;
         endcase
         if (state_d == StPulse && state_q != StPulse) begin
            pcnt_d     = '0;
            credited_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         owed_q     <= '0;
         paid_q     <= '0;
         pcnt_q     <= '0;
         tmr_q      <= '0;
         retry_q    <= '0;
         credited_q <= 1'b0;
         eject      <= 1'b0;
         done       <= 1'b0;
         fault      <= 1'b0;
         busy       <= 1'b0;
         req_ready  <= 1'b1;
`ifdef CHANGE_PAYOUT_ABORT_EN
         aborted    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         owed_q     <= owed_d;
         paid_q     <= paid_d;
         pcnt_q     <= pcnt_d;
         tmr_q      <= tmr_d;
         retry_q    <= retry_d;
         credited_q <= credited_d;
         eject      <= (state_d == StPulse);
         done       <= (state_d == StDone);
         fault      <= (state_d == StFault);
         busy       <= (state_d != StIdle);
         req_ready  <= (state_d == StIdle);
`ifdef CHANGE_PAYOUT_ABORT_EN
         aborted    <= abort_hit;
`endif
      end
   end

   assign owed = owed_q;
   assign paid = paid_q;

endmodule

// File: tb/tb_change_payout_ctrl.sv
// Scoreboard bench for change_payout_ctrl: a sensor responder follows a per-pulse answer plan,
// and a monitor checks pulse shape and each completed request against the expected payout.
module tb_change_payout_ctrl;
   localparam int unsigned AMT_W       = 4;
   localparam int unsigned COIN_VAL    = 5;
   localparam int unsigned PULSE_CYC   = 4;
   localparam int unsigned TIMEOUT_CYC = 16;
   localparam int unsigned MAX_RETRY   = 2;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic             req_valid = 1'b0;
   logic [AMT_W-1:0] req_amount = '0;
   logic             req_ready, eject, busy, done, fault;
   logic             coin_seen = 1'b0;
   logic             fault_clr = 1'b0;
   logic [AMT_W-1:0] owed, paid;
`ifdef CHANGE_PAYOUT_ABORT_EN
   logic             abort = 1'b0;
   logic             aborted;
`endif

   typedef struct {
      int paid;
      int owed;
      int pulses;
      int aborted;
   } exp_t;

   exp_t sb[$];
   bit   plan[$];
   int   checks = 0, errors = 0;
   int   rises = 0, width = 0, done_cnt = 0, exp_done = 0, fixed_d = 0;
   bit   ej_prev = 1'b0, chk_ready = 1'b0;

   always #5 clock = ~clock;

   change_payout_ctrl #(
      .AMT_W(AMT_W), .COIN_VAL(COIN_VAL), .PULSE_CYC(PULSE_CYC),
      .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_amount(req_amount),
      .req_ready(req_ready), .eject(eject), .coin_seen(coin_seen), .fault_clr(fault_clr),
`ifdef CHANGE_PAYOUT_ABORT_EN
      .abort(abort), .aborted(aborted),
`endif
      .busy(busy), .done(done), .fault(fault), .owed(owed), .paid(paid)
   );

   task automatic check_eq(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per coin: 'misses' silent pulses then one answered pulse (misses<0 picks at random).
   task automatic plan_req(input int amount, input int misses, output int pulses);
      int m;
      pulses = 0;
      for (int c = 0; c < amount / int'(COIN_VAL); c++) begin
         m = (misses < 0) ? int'($urandom_range(0, MAX_RETRY)) : misses;
         for (int k = 0; k < m; k++) plan.push_back(1'b0);
         plan.push_back(1'b1);
         pulses += m + 1;
      end
   endtask

   task automatic expect_req(input int amount, input int pulses);
      exp_t e;
      e.paid = amount - (amount % int'(COIN_VAL));
      e.owed = 0;
      e.pulses = pulses;
      e.aborted = 0;
      sb.push_back(e);
      exp_done++;
   endtask

   task automatic send(input int amount);
      int n = 0;
      int lat;
      @(negedge clock);
      while (!req_ready && n < 500) begin
         @(negedge clock);
         n++;
      end
      check_eq("req_ready_before_send", int'(req_ready), 1);
      req_valid  = 1'b1;
      req_amount = AMT_W'(amount);
      @(negedge clock);
      req_valid = 1'b0;
      lat = amount - (amount % int'(COIN_VAL));
      check_eq("owed_latched", int'(owed), lat);
      check_eq("paid_cleared", int'(paid), 0);
      check_eq("first_eject_latency", int'(eject), (lat != 0) ? 1 : 0);
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while (done_cnt < exp_done && n < 2000) begin
         @(negedge clock);
         n++;
      end
      check_eq(name, done_cnt, exp_done);
   endtask

   // Sensor responder: answers a planned pulse d cycles after eject rises (1..PULSE+TIMEOUT).
   initial begin
      int cd = 0;
      int d;
      bit prev = 1'b0;
      bit ans;
      forever begin
         @(negedge clock);
         coin_seen = 1'b0;
         if (!reset_n) begin
            cd = 0;
            prev = 1'b0;
         end else begin
            if (cd > 0) begin
               cd--;
               if (cd == 0) coin_seen = 1'b1;
            end
            if (eject && !prev) begin
               ans = (plan.size() > 0) ? plan.pop_front() : 1'b0;
               if (ans) begin
                  d = (fixed_d > 0) ? fixed_d : int'($urandom_range(1, PULSE_CYC + TIMEOUT_CYC));
                  if (d == 1) coin_seen = 1'b1;
                  else cd = d - 1;
               end
            end
            prev = eject;
         end
      end
   end

   // Monitor: pulse shape, then pop and compare on every done.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset_n) begin
            ej_prev = 1'b0;
            width = 0;
            rises = 0;
            chk_ready = 1'b0;
         end else begin
            if (chk_ready) begin
               check_eq("ready_after_done", int'(req_ready), 1);
               chk_ready = 1'b0;
            end
            if (eject) begin
               if (!ej_prev) rises++;
               width++;
            end else if (ej_prev) begin
               check_eq("pulse_width", width, PULSE_CYC);
               width = 0;
            end
            if (done) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done actual=1 expected=0 at %0t", $time);
               end else begin
                  e = sb.pop_front();
                  check_eq("done_paid", int'(paid), e.paid);
                  check_eq("done_owed", int'(owed), e.owed);
                  check_eq("done_pulses", rises, e.pulses);
`ifdef CHANGE_PAYOUT_ABORT_EN
                  check_eq("done_aborted", int'(aborted), e.aborted);
`endif
               end
               rises = 0;
               chk_ready = 1'b1;
               done_cnt++;
            end
            ej_prev = eject;
         end
      end
   end

   initial begin
      int p;
      int n;
      int a;
      exp_t e;

      // Reset state
      repeat (3) @(negedge clock);
      check_eq("rst_eject", int'(eject), 0);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_done", int'(done), 0);
      check_eq("rst_fault", int'(fault), 0);
      check_eq("rst_owed", int'(owed), 0);
      check_eq("rst_paid", int'(paid), 0);
      reset_n = 1'b1;
      @(negedge clock);
      check_eq("rst_req_ready", int'(req_ready), 1);

      // 15 with sensor 2 cycles after each pulse
      fixed_d = PULSE_CYC + 2;
      plan_req(15, 0, p);
      expect_req(15, p);
      send(15);
      wait_done("done_amt15");

      // Zero amount, then remainder dropped
      plan_req(0, 0, p);
      expect_req(0, p);
      send(0);
      wait_done("done_amt0");
      plan_req(7, 0, p);
      expect_req(7, p);
      send(7);
      wait_done("done_amt7");

      // Jam: 1 + MAX_RETRY silent pulses then fault, resume with fault_clr
      for (int k = 0; k < int'(MAX_RETRY) + 1; k++) plan.push_back(1'b0);
      expect_req(10, int'(MAX_RETRY) + 1 + 2);
      send(10);
      n = 0;
      while (!fault && n < 500) begin
         @(negedge clock);
         n++;
      end
      check_eq("fault_raised", int'(fault), 1);
      check_eq("fault_owed", int'(owed), 10);
      check_eq("fault_paid", int'(paid), 0);
      check_eq("fault_pulses", rises, int'(MAX_RETRY) + 1);
      check_eq("fault_eject", int'(eject), 0);
      repeat (5) @(negedge clock);
      check_eq("fault_held", int'(fault), 1);
      plan.push_back(1'b1);
      plan.push_back(1'b1);
      fault_clr = 1'b1;
      @(negedge clock);
      fault_clr = 1'b0;
      wait_done("done_after_fault");

      // Randomised requests with random sensor delay and random misses per coin
      fixed_d = 0;
      for (int r = 0; r < 20; r++) begin
         a = int'($urandom_range(0, (1 << AMT_W) - 1));
         plan_req(a, -1, p);
         expect_req(a, p);
         send(a);
         wait_done("done_random");
      end

      // Asynchronous reset mid-pulse
      fixed_d = PULSE_CYC + 2;
      plan_req(15, 0, p);
      send(15);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check_eq("async_rst_eject", int'(eject), 0);
      check_eq("async_rst_busy", int'(busy), 0);
      sb.delete();
      plan.delete();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check_eq("post_rst_ready", int'(req_ready), 1);
      check_eq("post_rst_owed", int'(owed), 0);
      check_eq("post_rst_paid", int'(paid), 0);

`ifdef CHANGE_PAYOUT_ABORT_EN
      // Abort after the first coin
      plan_req(15, 0, p);
      e.paid = 5;
      e.owed = 10;
      e.pulses = 1;
      e.aborted = 1;
      sb.push_back(e);
      exp_done++;
      send(15);
      n = 0;
      while (int'(paid) != 5 && n < 200) begin
         @(negedge clock);
         n++;
      end
      check_eq("abort_first_coin", int'(paid), 5);
      abort = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      wait_done("done_abort");
      repeat (30) @(negedge clock);
      check_eq("no_eject_after_abort", rises, 0);
      plan.delete();
`endif

      repeat (3) @(negedge clock);
      check_eq("scoreboard_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
